// File: rtl/cpu_pipe_pkg.sv
// Shared MEM/WB pipeline types: occupancy encoding, default widths and the
// registered payload layout used between memory stage and writeback.
package cpu_pipe_pkg;

   localparam int DEF_DATA_W     = 16;
   localparam int DEF_REG_ADDR_W = 3;
   localparam int DEF_NUM_ERR    = 2;

   // Occupancy doubles as the entry count held by the stage.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

   typedef struct packed {
      logic [DEF_DATA_W-1:0]     mem_data;
      logic [DEF_DATA_W-1:0]     alu_res;
      logic [DEF_REG_ADDR_W-1:0] write_reg;
      logic                      wr_reg_vld;
      logic                      mem_to_reg;
      logic                      reg_write;
      logic                      mem_read;
      logic                      err;
   } memwb_payload_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// One storage slot of the stage: a payload register plus its valid bit.
// clear has priority over load; clearing leaves the stale payload in place.
module pipe_skid_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);

   // Valid/payload register with asynchronous active-low reset to all zeros.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end
   end

endmodule

// File: rtl/memwb_stage_buf.sv
// MEM/WB pipeline stage with a head slot and a skid slot.
// Handshake: an entry moves upstream->stage when in_valid & in_ready and
// stage->downstream when out_valid & out_ready, both on the rising edge;
// in_ready depends only on registered state, never on out_ready.
module memwb_stage_buf
   import cpu_pipe_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int NUM_ERR    = DEF_NUM_ERR
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     mem_data_in,
   input  logic [DATA_W-1:0]     alu_res_in,
   input  logic [REG_ADDR_W-1:0] write_reg_in,
   input  logic                  wr_reg_vld_in,
   input  logic                  mem_to_reg_in,
   input  logic                  reg_write_in,
   input  logic                  mem_read_in,
   input  logic [NUM_ERR-1:0]    err_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     mem_data_out,
   output logic [DATA_W-1:0]     alu_res_out,
   output logic [REG_ADDR_W-1:0] write_reg_out,
   output logic                  wr_reg_vld_out,
   output logic                  mem_to_reg_out,
   output logic                  reg_write_out,
   output logic                  mem_read_out,
   output logic [DATA_W-1:0]     wb_data_out,
   output logic                  err_out,
   output occ_t                  occupancy
);

   typedef struct packed {
      logic [DATA_W-1:0]     mem_data;
      logic [DATA_W-1:0]     alu_res;
      logic [REG_ADDR_W-1:0] write_reg;
      logic                  wr_reg_vld;
      logic                  mem_to_reg;
      logic                  reg_write;
      logic                  mem_read;
      logic                  err;
   } payload_t;

   localparam int PW = $bits(payload_t);

   occ_t     state;
   occ_t     state_nxt;
   payload_t in_pl;
   payload_t head_d;
   payload_t head_q;
   payload_t skid_q;
   logic     head_valid;
   logic     skid_valid;
   logic     head_load;
   logic     head_clr;
   logic     head_from_skid;
   logic     skid_load;
   logic     skid_clr;
   logic     accept;
   logic     pop;

   // Error sources collapse to one flag that travels with the entry.
   assign in_pl = '{
      mem_data:   mem_data_in,
      alu_res:    alu_res_in,
      write_reg:  write_reg_in,
      wr_reg_vld: wr_reg_vld_in,
      mem_to_reg: mem_to_reg_in,
      reg_write:  reg_write_in,
      mem_read:   mem_read_in,
      err:        |err_in
   };

   assign in_ready  = !skid_valid;
   assign out_valid = head_valid;
   assign accept    = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign occupancy = state;

   // Occupancy state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= OCC_EMPTY;
      else      state <= state_nxt;
   end

   // Next occupancy and slot load/clear controls; flush overrides everything.
   always_comb begin
      state_nxt      = state;
      head_load      = 1'b0;
      head_clr       = 1'b0;
      head_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clr       = 1'b0;
      if (flush) begin
         state_nxt = OCC_EMPTY;
         head_clr  = 1'b1;
         skid_clr  = 1'b1;
      end else begin
         case (state)
            OCC_EMPTY: begin
               if (accept) begin
                  head_load = 1'b1;
                  state_nxt = OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (accept && pop) begin
                  head_load = 1'b1;
               end else if (pop) begin
                  head_clr  = 1'b1;
                  state_nxt = OCC_EMPTY;
               end else if (accept) begin
                  skid_load = 1'b1;
                  state_nxt = OCC_FULL;
               end
            end
            OCC_FULL: begin
               // in_ready is low here, so only the skid can refill the head.
               if (pop) begin
                  head_load      = 1'b1;
                  head_from_skid = 1'b1;
                  skid_clr       = 1'b1;
                  state_nxt      = OCC_ONE;
               end
            end
            default: begin
               state_nxt = OCC_EMPTY;
               head_clr  = 1'b1;
               skid_clr  = 1'b1;
            end
         endcase
      end
   end

   // Head reload source: the older skid entry when draining, else the input.
   always_comb begin
      head_d = in_pl;
      if (head_from_skid) head_d = skid_q;
   end

   pipe_skid_slot #(.W(PW)) u_head (
      .clk   (clk),
      .rst   (rst),
      .load  (head_load),
      .clear (head_clr),
      .d     (head_d),
      .valid (head_valid),
      .q     (head_q)
   );

   pipe_skid_slot #(.W(PW)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .clear (skid_clr),
      .d     (in_pl),
      .valid (skid_valid),
      .q     (skid_q)
   );

   // Bubble gating on control bits; data fields pass through unconditionally.
   always_comb begin
      mem_data_out   = head_q.mem_data;
      alu_res_out    = head_q.alu_res;
      write_reg_out  = head_q.write_reg;
      wr_reg_vld_out = head_q.wr_reg_vld & head_valid;
      mem_to_reg_out = head_q.mem_to_reg & head_valid;
      reg_write_out  = head_q.reg_write  & head_valid;
      mem_read_out   = head_q.mem_read   & head_valid;
      err_out        = head_q.err        & head_valid;
      wb_data_out    = mem_to_reg_out ? head_q.mem_data : head_q.alu_res;
   end

endmodule

// File: tb/tb_memwb_stage_buf.sv
// Directed bench for memwb_stage_buf: a 2-deep FIFO model predicts the stage,
// a negedge compare process checks every cycle, literal checks pin the model.
module tb_memwb_stage_buf;
   import cpu_pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] mem_data_in;
   logic [15:0] alu_res_in;
   logic [2:0]  write_reg_in;
   logic        wr_reg_vld_in;
   logic        mem_to_reg_in;
   logic        reg_write_in;
   logic        mem_read_in;
   logic [1:0]  err_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] mem_data_out;
   logic [15:0] alu_res_out;
   logic [2:0]  write_reg_out;
   logic        wr_reg_vld_out;
   logic        mem_to_reg_out;
   logic        reg_write_out;
   logic        mem_read_out;
   logic [15:0] wb_data_out;
   logic        err_out;
   occ_t        occupancy;

   int total = 0;
   int bad   = 0;

   memwb_payload_t exp_q[$];

   memwb_stage_buf dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .mem_data_in    (mem_data_in),
      .alu_res_in     (alu_res_in),
      .write_reg_in   (write_reg_in),
      .wr_reg_vld_in  (wr_reg_vld_in),
      .mem_to_reg_in  (mem_to_reg_in),
      .reg_write_in   (reg_write_in),
      .mem_read_in    (mem_read_in),
      .err_in         (err_in),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .mem_data_out   (mem_data_out),
      .alu_res_out    (alu_res_out),
      .write_reg_out  (write_reg_out),
      .wr_reg_vld_out (wr_reg_vld_out),
      .mem_to_reg_out (mem_to_reg_out),
      .reg_write_out  (reg_write_out),
      .mem_read_out   (mem_read_out),
      .wb_data_out    (wb_data_out),
      .err_out        (err_out),
      .occupancy      (occupancy)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: a FIFO of capacity two; flush empties it and drops the input.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_q.delete();
      end else begin
         memwb_payload_t p;
         logic acc;
         logic pp;
         acc = in_valid && (exp_q.size() < 2);
         pp  = out_ready && (exp_q.size() > 0);
         p.mem_data   = mem_data_in;
         p.alu_res    = alu_res_in;
         p.write_reg  = write_reg_in;
         p.wr_reg_vld = wr_reg_vld_in;
         p.mem_to_reg = mem_to_reg_in;
         p.reg_write  = reg_write_in;
         p.mem_read   = mem_read_in;
         p.err        = |err_in;
         if (flush) begin
            exp_q.delete();
         end else begin
            if (pp)  void'(exp_q.pop_front());
            if (acc) exp_q.push_back(p);
         end
      end
   end

   // Compare every cycle out of reset.
   always @(negedge clk) begin
      if (rst) begin
         chk("occ", 32'(occupancy), 32'(exp_q.size()));
         chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
         chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
         if (exp_q.size() > 0) begin
            chk("mem_data", 32'(mem_data_out), 32'(exp_q[0].mem_data));
            chk("alu_res", 32'(alu_res_out), 32'(exp_q[0].alu_res));
            chk("write_reg", 32'(write_reg_out), 32'(exp_q[0].write_reg));
            chk("wr_reg_vld", 32'(wr_reg_vld_out), 32'(exp_q[0].wr_reg_vld));
            chk("mem_to_reg", 32'(mem_to_reg_out), 32'(exp_q[0].mem_to_reg));
            chk("reg_write", 32'(reg_write_out), 32'(exp_q[0].reg_write));
            chk("mem_read", 32'(mem_read_out), 32'(exp_q[0].mem_read));
            chk("err", 32'(err_out), 32'(exp_q[0].err));
            chk("wb_data", 32'(wb_data_out),
                32'(exp_q[0].mem_to_reg ? exp_q[0].mem_data : exp_q[0].alu_res));
         end else begin
            chk("bub_ctrl", {27'd0, wr_reg_vld_out, mem_to_reg_out, reg_write_out,
                             mem_read_out, err_out}, 32'd0);
         end
      end
   end

   // Apply one cycle of inputs, return on the following negedge.
   task automatic drive(input logic iv, input logic ordy, input logic fl,
                        input logic [15:0] mem, input logic [15:0] alu,
                        input logic m2r, input logic rw, input logic [1:0] err);
      in_valid      = iv;
      out_ready     = ordy;
      flush         = fl;
      mem_data_in   = mem;
      alu_res_in    = alu;
      write_reg_in  = alu[2:0];
      wr_reg_vld_in = rw;
      mem_to_reg_in = m2r;
      reg_write_in  = rw;
      mem_read_in   = m2r;
      err_in        = err;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      mem_data_in = '0; alu_res_in = '0; write_reg_in = '0; wr_reg_vld_in = 1'b0;
      mem_to_reg_in = 1'b0; reg_write_in = 1'b0; mem_read_in = 1'b0; err_in = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_alu", 32'(alu_res_out), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 2'b00);

      // Stream: one entry per cycle, head follows input one cycle later.
      for (int i = 1; i <= 8; i++) begin
         drive(1, 1, 0, 16'h0, 16'(i), 0, 1, 2'b00);
         chk("stream_alu", 32'(alu_res_out), 32'(i));
         chk("stream_in_ready", 32'(in_ready), 32'd1);
      end
      drive(0, 1, 0, 16'h0, 16'h0, 0, 0, 2'b00);
      chk("stream_drained", 32'(out_valid), 32'd0);

      // Stall: A and B fill both slots, C waits, then all drain in order.
      drive(1, 0, 0, 16'h0, 16'h1111, 0, 1, 2'b00);
      drive(1, 0, 0, 16'h0, 16'h2222, 0, 1, 2'b00);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      drive(1, 0, 0, 16'h0, 16'h3333, 0, 1, 2'b00);
      chk("stall_head_a", 32'(alu_res_out), 32'h1111);
      drive(1, 1, 0, 16'h0, 16'h3333, 0, 1, 2'b00);
      chk("stall_head_b", 32'(alu_res_out), 32'h2222);
      drive(1, 1, 0, 16'h0, 16'h3333, 0, 1, 2'b00);
      chk("stall_head_c", 32'(alu_res_out), 32'h3333);
      drive(0, 1, 0, 16'h0, 16'h0, 0, 0, 2'b00);
      chk("stall_empty", 32'(out_valid), 32'd0);

      // Flush while full, with a new entry presented in the same cycle.
      drive(1, 0, 0, 16'h0, 16'h4444, 0, 1, 2'b00);
      drive(1, 0, 0, 16'h0, 16'h5555, 0, 1, 2'b00);
      drive(1, 0, 1, 16'h0, 16'h6666, 0, 1, 2'b00);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      drive(0, 1, 0, 16'h0, 16'h0, 0, 0, 2'b00);
      chk("flush_dropped", 32'(out_valid), 32'd0);

      // Writeback select and per-entry error flag.
      drive(1, 1, 0, 16'hBEEF, 16'h1234, 1, 1, 2'b00);
      chk("wb_mem", 32'(wb_data_out), 32'hBEEF);
      drive(1, 1, 0, 16'hBEEF, 16'h1234, 0, 1, 2'b00);
      chk("wb_alu", 32'(wb_data_out), 32'h1234);
      drive(1, 1, 0, 16'h0, 16'h0042, 0, 1, 2'b10);
      chk("err_set", 32'(err_out), 32'd1);
      drive(1, 1, 0, 16'h0, 16'h0043, 0, 1, 2'b00);
      chk("err_next_clear", 32'(err_out), 32'd0);

      // Bubble: control inputs asserted without in_valid must not leak out.
      drive(0, 1, 0, 16'h0, 16'h0077, 1, 1, 2'b11);
      chk("bubble_reg_write", 32'(reg_write_out), 32'd0);
      chk("bubble_out_valid", 32'(out_valid), 32'd0);

      // Reset in the middle of a full stage discards both entries.
      drive(1, 0, 0, 16'h0, 16'h0A0A, 1, 1, 2'b01);
      drive(1, 0, 0, 16'h0, 16'h0B0B, 1, 1, 2'b01);
      chk("prerst_full", 32'(in_ready), 32'd0);
      #2 rst = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_reg_write", 32'(reg_write_out), 32'd0);
      chk("midrst_err", 32'(err_out), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 2'b00);
      chk("postrst_in_ready", 32'(in_ready), 32'd1);
      chk("postrst_out_valid", 32'(out_valid), 32'd0);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
